stream_demux: RTL

//  Valid/ready stream demultiplexer, the inverse of a mux: one input stream is steered to one of N_OUT

---
 rtl/stream_demux.sv | 80 ++++++++
 1 files changed

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer: one registered hold entry steers each item to the output
// named by its destination tag; out-of-range tags are consumed and flagged with a drop pulse.
module stream_demux #(
   parameter int N_OUT  = 4,
   parameter int W      = 8,
   parameter int DEST_W = 3,
   parameter int CW     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        in_data,
   input  logic [DEST_W-1:0]   in_dest,
   output logic [N_OUT-1:0]    out_valid,
   input  logic [N_OUT-1:0]    out_ready,
   output logic [W-1:0]        out_data,
   output logic                drop,
   output logic [N_OUT*CW-1:0] out_cnt
);

   // One extra bit so the range check still works when N_OUT == 2**DEST_W.
   localparam logic [DEST_W:0] N_OUT_EXT = (DEST_W+1)'(N_OUT);

   logic              hold_valid_reg;
   logic [W-1:0]      hold_data_reg;
   logic [DEST_W-1:0] hold_dest_reg;
   logic              drop_reg;
   logic [CW-1:0]     cnt_reg [N_OUT];

   logic [N_OUT-1:0]  xfer;
   logic              drain;
   logic              accept;
   logic              in_range;

   genvar gi;
   generate
      for (gi = 0; gi < N_OUT; gi++) begin : g_out
         assign out_valid[gi] = hold_valid_reg && (hold_dest_reg == DEST_W'(gi));
         assign xfer[gi]      = out_valid[gi] && out_ready[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg[gi] <= '0;
            end else if (xfer[gi]) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
         end

         assign out_cnt[gi*CW +: CW] = cnt_reg[gi];
      end
   endgenerate

   // The selected output's ready passes straight through as input space.
   assign drain    = |xfer;
   assign in_ready = !rst && (!hold_valid_reg || drain);
   assign accept   = in_valid && in_ready;
   assign in_range = {1'b0, in_dest} < N_OUT_EXT;
   assign out_data = hold_data_reg;
   assign drop     = drop_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_reg <= 1'b0;
         hold_data_reg  <= '0;
         hold_dest_reg  <= '0;
         drop_reg       <= 1'b0;
      end else begin
         drop_reg <= accept && !in_range;
         if (accept && in_range) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= in_data;
            hold_dest_reg  <= in_dest;
         end else if (drain) begin
            hold_valid_reg <= 1'b0;
         end
      end
   end

endmodule
